// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: counts O from the loaded value to zero on CE and pulses DONE for one cycle at expiry.
// Load accepted only while idle; ABORT cancels a countdown; optional auto-reload re-arms from the last accepted value.
module down_counter_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD_VALID,
    input  logic [WIDTH-1:0] LOAD_DATA,
    output logic             LOAD_READY,
    input  logic             CE,
    input  logic             ABORT,
    output logic [WIDTH-1:0] O,
    output logic             ZERO,
    output logic             DONE,
    output logic             BUSY
);

    typedef enum logic [1:0] {IDLE, COUNT, EXPIRE} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload;
    logic             done_q;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (LOAD_VALID) begin
                        count  <= LOAD_DATA;
                        reload <= LOAD_DATA;
                        if (LOAD_DATA == '0) begin
                            state  <= EXPIRE;
                            done_q <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    // ABORT wins over the final decrement, so no DONE can slip out.
                    if (ABORT) begin
                        state <= IDLE;
                    end else if (CE) begin
                        if (count <= ONE) begin
                            count  <= '0;
                            state  <= EXPIRE;
                            done_q <= 1'b1;
                        end else begin
                            count <= count - ONE;
                        end
                    end
                end
                EXPIRE: begin
                    if (AUTO_RELOAD && !ABORT) begin
                        count <= reload;
                        if (reload == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign O          = count;
    assign ZERO       = (count == '0);
    assign DONE       = done_q;
    assign BUSY       = (state != IDLE);
    assign LOAD_READY = (state == IDLE) && RESET;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: one plain and one auto-reload instance share stimulus and are
// checked every cycle against a behavioural model, plus directed scenario checks.
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv;
    logic [3:0] ld;
    logic       ce;
    logic       ab;

    logic       rdy_s  [2];
    logic [3:0] o_s    [2];
    logic       zero_s [2];
    logic       done_s [2];
    logic       busy_s [2];

    int checks = 0;
    int errors = 0;

    // Model: timer is either idle, counting down "m_o" units, or sitting in its expiry cycle.
    bit m_idle [2];
    bit m_exp  [2];
    int m_o    [2];
    int m_rl   [2];

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
        .CLK(clk), .RESET(rst), .LOAD_VALID(lv), .LOAD_DATA(ld), .LOAD_READY(rdy_s[0]),
        .CE(ce), .ABORT(ab), .O(o_s[0]), .ZERO(zero_s[0]), .DONE(done_s[0]), .BUSY(busy_s[0])
    );

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
        .CLK(clk), .RESET(rst), .LOAD_VALID(lv), .LOAD_DATA(ld), .LOAD_READY(rdy_s[1]),
        .CE(ce), .ABORT(ab), .O(o_s[1]), .ZERO(zero_s[1]), .DONE(done_s[1]), .BUSY(busy_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input bit ar);
        if (!rst) begin
            m_idle[i] = 1; m_exp[i] = 0; m_o[i] = 0; m_rl[i] = 0;
        end else if (m_exp[i]) begin
            if (ar && !ab) begin
                m_o[i]   = m_rl[i];
                m_exp[i] = (m_rl[i] == 0);
            end else begin
                m_idle[i] = 1; m_exp[i] = 0;
            end
        end else if (m_idle[i]) begin
            if (lv) begin
                m_o[i] = ld; m_rl[i] = ld;
                m_idle[i] = 0; m_exp[i] = (ld == 0);
            end
        end else if (ab) begin
            m_idle[i] = 1;
        end else if (ce) begin
            m_o[i]   = (m_o[i] > 0) ? m_o[i] - 1 : 0;
            m_exp[i] = (m_o[i] == 0);
        end
    endtask

    // One clock: advance the models with the inputs seen at the edge, then compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_o%0d", i),    o_s[i],    m_o[i]);
            chk($sformatf("model_zero%0d", i), zero_s[i], (m_o[i] == 0));
            chk($sformatf("model_done%0d", i), done_s[i], m_exp[i]);
            chk($sformatf("model_busy%0d", i), busy_s[i], !m_idle[i]);
            chk($sformatf("model_rdy%0d", i),  rdy_s[i],  m_idle[i] && rst);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; lv = 1'b0; ld = '0; ce = 1'b0; ab = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; lv = 1'b0; ld = '0; ce = 1'b0; ab = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_idle[i] = 1; m_exp[i] = 0; m_o[i] = 0; m_rl[i] = 0;
        end
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_o", o_s[0], 0);
        chk("rst_done", done_s[0], 0);
        chk("rst_busy", busy_s[0], 0);
        chk("rst_rdy_low", rdy_s[0], 0);
        lv = 1'b1; ld = 4'd5;
        cyc();
        chk("rst_load_ignored", o_s[0], 0);
        lv = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_busy", busy_s[0], 0);
        chk("post_rst_zero", zero_s[0], 1);
        chk("post_rst_rdy", rdy_s[0], 1);

        // Load 5 with CE held high.
        lv = 1'b1; ld = 4'd5; ce = 1'b1;
        cyc();
        lv = 1'b0;
        chk("l5_o_first", o_s[0], 5);
        for (int k = 4; k >= 0; k--) begin
            cyc();
            chk($sformatf("l5_o_%0d", k), o_s[0], k);
            chk($sformatf("l5_done_%0d", k), done_s[0], (k == 0));
        end
        cyc();
        chk("l5_busy_after", busy_s[0], 0);
        chk("l5_rdy_after", rdy_s[0], 1);
        chk("l5_done_after", done_s[0], 0);

        // Load 3 with CE toggled 1,0,1,0,1.
        do_reset();
        lv = 1'b1; ld = 4'd3;
        cyc();
        lv = 1'b0;
        chk("l3_o_first", o_s[0], 3);
        begin
            bit ce_seq [5] = '{1, 0, 1, 0, 1};
            int o_exp  [5] = '{2, 2, 1, 1, 0};
            for (int k = 0; k < 5; k++) begin
                ce = ce_seq[k];
                cyc();
                chk($sformatf("l3_o_step%0d", k), o_s[0], o_exp[k]);
                chk($sformatf("l3_done_step%0d", k), done_s[0], (k == 4));
            end
        end
        ce = 1'b0;
        cyc();
        chk("l3_done_once", done_s[0], 0);

        // Load 0: immediate expiry.
        do_reset();
        lv = 1'b1; ld = 4'd0;
        cyc();
        lv = 1'b0;
        chk("l0_done", done_s[0], 1);
        chk("l0_o", o_s[0], 0);
        cyc();
        chk("l0_busy_next", busy_s[0], 0);
        chk("l0_done_next", done_s[0], 0);

        // Load 4, abort together with the final decrement.
        do_reset();
        lv = 1'b1; ld = 4'd4; ce = 1'b1;
        cyc();
        lv = 1'b0;
        cyc(); cyc(); cyc();
        chk("ab_o_before", o_s[0], 1);
        ab = 1'b1;
        cyc();
        ab = 1'b0;
        chk("ab_o_hold", o_s[0], 1);
        chk("ab_no_done", done_s[0], 0);
        chk("ab_busy", busy_s[0], 0);
        chk("ab_rdy", rdy_s[0], 1);
        cyc();
        chk("ab_no_late_done", done_s[0], 0);

        // Auto-reload instance: load 2, load attempt of 7 during the countdown must be ignored.
        do_reset();
        lv = 1'b1; ld = 4'd2; ce = 1'b1;
        cyc();
        chk("ar_o_first", o_s[1], 2);
        ld = 4'd7;
        begin
            int o_exp [5] = '{1, 0, 2, 1, 0};
            for (int k = 0; k < 5; k++) begin
                cyc();
                lv = 1'b0;
                chk($sformatf("ar_o_step%0d", k), o_s[1], o_exp[k]);
                chk($sformatf("ar_done_step%0d", k), done_s[1], (o_exp[k] == 0));
            end
        end

        // Reset in the middle of a countdown.
        do_reset();
        lv = 1'b1; ld = 4'd8; ce = 1'b1;
        cyc();
        lv = 1'b0;
        cyc(); cyc();
        chk("mr_o_before", o_s[0], 6);
        rst = 1'b0;
        cyc();
        chk("mr_o", o_s[0], 0);
        chk("mr_busy", busy_s[0], 0);
        chk("mr_done", done_s[0], 0);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("mr_no_done%0d", k), done_s[0], 0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            lv  = ($urandom_range(0, 2) == 0);
            ld  = 4'($urandom_range(0, 15));
            ce  = ($urandom_range(0, 2) != 0);
            ab  = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the count register width in bits (legal 2..16).
REQ-002 The block SHALL have parameter AUTO_RELOAD, default 0, meaning that when set to 1 the block reloads the last accepted value after each expiry.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have port LOAD_VALID, input, 1 bit, indicating a load request.
REQ-006 The block SHALL have port LOAD_DATA, input, WIDTH bits, the start value for the countdown.
REQ-007 The block SHALL have port LOAD_READY, output, 1 bit, indicating that a load will be accepted.
REQ-008 The block SHALL have port CE, input, 1 bit, the count enable for decrementing.
REQ-009 The block SHALL have port ABORT, input, 1 bit, which cancels an active countdown.
REQ-010 The block SHALL have port O, output, WIDTH bits, the current count value (registered).
REQ-011 The block SHALL have port ZERO, output, 1 bit, equal to (O == 0) combinationally.
REQ-012 The block SHALL have port DONE, output, 1 bit, a registered one-cycle expiry pulse.
REQ-013 The block SHALL have port BUSY, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement exactly three states: IDLE, COUNT and EXPIRE.
REQ-015 LOAD_READY SHALL be high only in IDLE with RESET high; a load is accepted on a CLK edge where LOAD_VALID && LOAD_READY.
REQ-016 On load acceptance, O SHALL take LOAD_DATA on that edge and LOAD_DATA SHALL be stored in an internal reload register.
REQ-017 On load acceptance with LOAD_DATA != 0, next state SHALL be COUNT; with LOAD_DATA == 0, next state SHALL be EXPIRE.
REQ-018 In COUNT with CE=1 and ABORT=0: O SHALL decrement by 1 per edge; when O==1, O SHALL become 0 and next state SHALL be EXPIRE.
REQ-019 In COUNT with CE=0, O and state SHALL hold.
REQ-020 O SHALL never decrement below 0: no wrap-around from 0 to 2^WIDTH-1.
REQ-021 In COUNT with ABORT=1, next state SHALL be IDLE, O SHALL hold its current value, and no DONE SHALL be produced; ABORT overrides a simultaneous final decrement.
REQ-022 In EXPIRE, DONE SHALL be 1 for exactly that one cycle and O SHALL read 0.
REQ-023 From EXPIRE with AUTO_RELOAD=0, next state SHALL be IDLE.
REQ-024 From EXPIRE with AUTO_RELOAD=1, O SHALL take the reload register value; next state SHALL be COUNT if that value != 0, else EXPIRE again, giving a DONE every cycle.
REQ-025 ABORT in EXPIRE SHALL be ignored (the DONE pulse completes); with AUTO_RELOAD=1, ABORT in EXPIRE SHALL force next state IDLE.
REQ-026 LOAD_VALID outside IDLE SHALL be ignored, with no side effect on O or the reload register.
REQ-027 CE SHALL have no effect in IDLE or EXPIRE.
REQ-028 Load-to-DONE latency with CE held high SHALL be exactly N+1 edges for LOAD_DATA=N (N>=1), and 1 edge for N=0.

Reset
REQ-029 On a CLK edge with RESET=0: state SHALL become IDLE, O SHALL become 0, DONE SHALL become 0 and the reload register SHALL become 0.
REQ-030 While RESET=0, LOAD_READY SHALL be 0 and loads SHALL be ignored.
REQ-031 RESET SHALL take priority over all other inputs, including mid-countdown and in EXPIRE.
REQ-032 After reset release, BUSY SHALL be 0, ZERO SHALL be 1 and LOAD_READY SHALL be 1.

Verification
REQ-033 The bench SHALL cover: load 5, CE=1 constantly -> O reads 5,4,3,2,1,0; DONE high on the edge-6 cycle only; then BUSY=0 and LOAD_READY=1.
REQ-034 The bench SHALL cover: load 3, CE toggled 1,0,1,0,1 -> O reads 3,2,2,1,1,0; DONE once after O reaches 0.
REQ-035 The bench SHALL cover: load 0 -> DONE high the next cycle; O=0; back to IDLE the following cycle.
REQ-036 The bench SHALL cover: load 4, ABORT at O=1 together with CE=1 -> O holds 1, no DONE, IDLE, LOAD_READY=1.
REQ-037 The bench SHALL cover: AUTO_RELOAD=1, load 2, CE=1 -> DONE every 3 cycles, O sequence 2,1,0,2,1,0; LOAD_VALID with data 7 during COUNT is ignored.
REQ-038 The bench SHALL cover: RESET=0 asserted at O=6 mid-COUNT -> next edge O=0, BUSY=0, DONE=0; no DONE produced afterwards.
